multicycle_control_fsm: RTL and testbench
=========================================

// Module: multicycle_control_fsm
// PURPOSE
// Parametrised multicycle RV32I control unit: sequences FETCH/DECODE/EXEC/MEM/WB per instruction.
// Decodes the latched instruction into ALU op, datapath selects and strobes, and waits on a memory
// ready handshake with a timeout. Sits between unified instruction/data memory port and the datapath.
// PARAMETERS
// ALUOP_W   4   width of alu_op (>=4)
// WAIT_W    4   width of memory-wait counter
// MAX_WAIT  15  cycles of mem_ready low tolerated in FETCH/MEM before FAULT (<2**WAIT_W)
// PORTS
// clk        in   1        single clock, rising edge
// reset      in   1        synchronous, active-high
// instr      in   32       memory read data; latched into IR when FETCH && mem_ready
// mem_ready  in   1        memory handshake; completes current FETCH/MEM access
// mem_read   out  1        memory read request (FETCH, MEM of load)
// mem_write  out  1        memory write request (MEM of store)
// iord       out  1        0=PC addresses memory (FETCH), 1=ALU result (MEM)
// ir_write   out  1        IR load strobe
// pc_write   out  1        PC update strobe
// pc_sel     out  2        0=PC+4, 1=branch/jal target, 2=jalr target (ALU&~1)
// branch     out  1        conditional PC update; datapath gates with compare result
// reg_write  out  1        register file write strobe
// wb_sel     out  2        0=ALU, 1=mem data, 2=PC+4
// alu_src    out  1        0=rs2, 1=immediate
// alu_op     out  ALUOP_W  ALU operation
// busy       out  1        high when not in FETCH
// fault      out  1        sticky; high in FAULT
// BEHAVIOUR
// - Reset: state=FETCH, wait counter=0, IR=0. All outputs 0 while reset is high.
// - Outputs are Moore-decoded from state and IR.
// - FETCH: mem_read=1, iord=0. On mem_ready: ir_write=1, pc_write=1, pc_sel=0, go to DECODE.
// - DECODE: 1 cycle, no strobes, go to EXEC. Unknown opcode follows CONFIGURATION.
// - EXEC: alu_op/alu_src valid.
//   - R(0x33)/I-ALU(0x13)/LUI(0x37)/AUIPC(0x17) -> WB.
//   - LOAD(0x03)/STORE(0x23) -> MEM, alu_op=ADD.
//   - BRANCH(0x63): branch=1, pc_sel=1, alu_op=SUB (beq/bne) or SLT/SLTU -> FETCH.
//   - JAL(0x6F)/JALR(0x67): pc_write=1, pc_sel=1/2 -> WB.
// - MEM: iord=1, mem_read (load) or mem_write (store) held until mem_ready.
//   - Load -> WB.
//   - Store -> FETCH.
// - WB: reg_write=1 for exactly 1 cycle. wb_sel=1 load, 2 jal/jalr, 0 otherwise. Go to FETCH.
// - Minimum latency (zero-wait memory): ALU 4 cycles; load 5; store 4; branch 3; jump 4.
// - alu_op encoding: ADD0 SUB1 AND2 OR3 SLL4 SRL5 XOR6 SLT7 SRA8 SLTU9 PASSB10.
//   - Decoded from standard funct3/funct7: funct7=0x20 selects SUB/SRA.
//   - I-type: SUB never decoded; funct7 checked only for shifts.
//   - LUI=PASSB; AUIPC=ADD.
// - Wait counter: increments each FETCH/MEM cycle with mem_ready=0; clears on mem_ready or state exit.
//   - Counter==MAX_WAIT with mem_ready=0 -> FAULT next cycle.
//   - mem_ready in that same cycle wins: access completes, no fault.
// - FAULT: all strobes 0, fault=1, busy=1. Exit only by reset.
// - Reset mid-access: request drops on the same edge; no write strobe after the reset edge.
// CONFIGURATION
// - Macro ILLEGAL_TRAP_EN:
//   - Defined: unknown opcode, or undefined funct3/funct7 combination, in DECODE -> FAULT; fault=1.
//   - Undefined: the instruction is a NOP. DECODE -> FETCH; no reg_write/mem_write/pc_write beyond fetch.
// TESTING
// 1. add x3,x1,x2 (0x002081B3), mem_ready=1 -> states F,D,E,W. reg_write=1 only in cycle 4, alu_op=0.
// 2. lw (0x0000A183), mem_ready low 3 cycles in MEM -> mem_read held 4 MEM cycles, then WB with wb_sel=1.
// 3. sw (0x0020A023) -> mem_write=1 in MEM with iord=1, back to FETCH. reg_write never 1.
// 4. mem_ready stuck 0 in FETCH -> fault=1 after MAX_WAIT+1 cycles.
//    Variant: mem_ready=1 exactly on cycle MAX_WAIT -> no fault.
// 5. opcode 0x7F: with ILLEGAL_TRAP_EN -> FAULT after DECODE.
//    Without it -> FETCH next, no strobes.
// 6. reset asserted during MEM of sw -> mem_write=0 next cycle. After release, mem_read=1 in FETCH.

Source files
------------

// File: rtl/multicycle_control_if.sv
// Control-unit boundary: memory handshake in, datapath/memory strobes out.
// master = control unit, slave = datapath/memory side.
interface multicycle_control_if #(
   parameter int ALUOP_W = 4
);
   logic [31:0]        instr;
   logic               mem_ready;
   logic               mem_read;
   logic               mem_write;
   logic               iord;
   logic               ir_write;
   logic               pc_write;
   logic [1:0]         pc_sel;
   logic               branch;
   logic               reg_write;
   logic [1:0]         wb_sel;
   logic               alu_src;
   logic [ALUOP_W-1:0] alu_op;
   logic               busy;
   logic               fault;

   modport master (
      input  instr, mem_ready,
      output mem_read, mem_write, iord, ir_write, pc_write, pc_sel, branch,
             reg_write, wb_sel, alu_src, alu_op, busy, fault
   );

   modport slave (
      output instr, mem_ready,
      input  mem_read, mem_write, iord, ir_write, pc_write, pc_sel, branch,
             reg_write, wb_sel, alu_src, alu_op, busy, fault
   );
endinterface

// File: rtl/multicycle_control_fsm.sv
// Multicycle RV32I control unit: FETCH/DECODE/EXEC/MEM/WB with memory-wait timeout.
// Optional macro ILLEGAL_TRAP_EN: illegal instructions trap to FAULT instead of acting as NOPs.
//
// state    | meaning
// S_FETCH  | read instruction at PC; latch IR and bump PC on mem_ready
// S_DECODE | one-cycle decode of the latched opcode/funct fields
// S_EXEC   | ALU operation; branch compare or jump PC update
// S_MEM    | load/store access at ALU address, held until mem_ready
// S_WB     | single-cycle register file write
// S_FAULT  | memory timeout or trapped illegal instruction; left only by reset
module multicycle_control_fsm #(
   parameter int ALUOP_W  = 4,
   parameter int WAIT_W   = 4,
   parameter int MAX_WAIT = 15
) (
   input logic                  clk,
   input logic                  reset,
   multicycle_control_if.master bus
);
   typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_FAULT} state_t;
   typedef enum logic [2:0] {K_ALU, K_LOAD, K_STORE, K_BRANCH, K_JAL, K_JALR, K_BAD} kind_t;

   localparam logic [ALUOP_W-1:0] OP_ADD   = ALUOP_W'(0);
   localparam logic [ALUOP_W-1:0] OP_SUB   = ALUOP_W'(1);
   localparam logic [ALUOP_W-1:0] OP_AND   = ALUOP_W'(2);
   localparam logic [ALUOP_W-1:0] OP_OR    = ALUOP_W'(3);
   localparam logic [ALUOP_W-1:0] OP_SLL   = ALUOP_W'(4);
   localparam logic [ALUOP_W-1:0] OP_SRL   = ALUOP_W'(5);
   localparam logic [ALUOP_W-1:0] OP_XOR   = ALUOP_W'(6);
   localparam logic [ALUOP_W-1:0] OP_SLT   = ALUOP_W'(7);
   localparam logic [ALUOP_W-1:0] OP_SRA   = ALUOP_W'(8);
   localparam logic [ALUOP_W-1:0] OP_SLTU  = ALUOP_W'(9);
   localparam logic [ALUOP_W-1:0] OP_PASSB = ALUOP_W'(10);
   localparam logic [WAIT_W-1:0]  WAIT_MAX = WAIT_W'(MAX_WAIT);

   state_t            state;
   logic [WAIT_W-1:0] wait_cnt;
   // Control copy of the IR keeps only the fields the decoder looks at.
   logic [6:0]        ir_op;
   logic [2:0]        ir_f3;
   logic [6:0]        ir_f7;
   kind_t             kind;
   logic [ALUOP_W-1:0] dec_alu;
   logic              dec_src;

   function automatic logic [ALUOP_W-1:0] f3_op(input logic [2:0] f3, input logic alt);
      case (f3)
         3'd0:    f3_op = alt ? OP_SUB : OP_ADD;
         3'd1:    f3_op = OP_SLL;
         3'd2:    f3_op = OP_SLT;
         3'd3:    f3_op = OP_SLTU;
         3'd4:    f3_op = OP_XOR;
         3'd5:    f3_op = alt ? OP_SRA : OP_SRL;
         3'd6:    f3_op = OP_OR;
         default: f3_op = OP_AND;
      endcase
   endfunction

   always_comb begin
      kind    = K_BAD;
      dec_alu = OP_ADD;
      dec_src = 1'b1;
      case (ir_op)
         7'h33: begin
            dec_src = 1'b0;
            dec_alu = f3_op(ir_f3, ir_f7 == 7'h20);
            if (ir_f7 == 7'h00 || (ir_f7 == 7'h20 && (ir_f3 == 3'd0 || ir_f3 == 3'd5)))
               kind = K_ALU;
         end
         7'h13: begin
            // Immediate ALU ops never subtract; funct7 only qualifies the shifts.
            dec_alu = f3_op(ir_f3, ir_f3 == 3'd5 && ir_f7 == 7'h20);
            if (ir_f3 == 3'd1) begin
               if (ir_f7 == 7'h00) kind = K_ALU;
            end else if (ir_f3 == 3'd5) begin
               if (ir_f7 == 7'h00 || ir_f7 == 7'h20) kind = K_ALU;
            end else begin
               kind = K_ALU;
            end
         end
         7'h37: begin
            kind    = K_ALU;
            dec_alu = OP_PASSB;
         end
         7'h17: kind = K_ALU;
         7'h03: if (ir_f3 != 3'd3 && ir_f3 != 3'd6 && ir_f3 != 3'd7) kind = K_LOAD;
         7'h23: if (ir_f3 <= 3'd2) kind = K_STORE;
         7'h63: begin
            dec_src = 1'b0;
            dec_alu = ir_f3[2] ? (ir_f3[1] ? OP_SLTU : OP_SLT) : OP_SUB;
            if (ir_f3[2:1] != 2'b01) kind = K_BRANCH;
         end
         7'h6F: kind = K_JAL;
         7'h67: if (ir_f3 == 3'd0) kind = K_JALR;
         default: kind = K_BAD;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= S_FETCH;
         wait_cnt <= '0;
         ir_op    <= '0;
         ir_f3    <= '0;
         ir_f7    <= '0;
      end else begin
         case (state)
            S_FETCH, S_MEM: begin
               if (bus.mem_ready) begin
                  wait_cnt <= '0;
                  if (state == S_FETCH) begin
                     ir_op <= bus.instr[6:0];
                     ir_f3 <= bus.instr[14:12];
                     ir_f7 <= bus.instr[31:25];
                     state <= S_DECODE;
                  end else begin
                     state <= (kind == K_LOAD) ? S_WB : S_FETCH;
                  end
               end else if (wait_cnt == WAIT_MAX) begin
                  wait_cnt <= '0;
                  state    <= S_FAULT;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end
            S_DECODE: begin
               if (kind == K_BAD) begin
`ifdef ILLEGAL_TRAP_EN
                  state <= S_FAULT;
`else
                  state <= S_FETCH;
`endif
               end else begin
                  state <= S_EXEC;
               end
            end
            S_EXEC: begin
               case (kind)
                  K_LOAD, K_STORE: state <= S_MEM;
                  K_BRANCH:        state <= S_FETCH;
                  default:         state <= S_WB;
               endcase
            end
            S_WB:    state <= S_FETCH;
            default: state <= S_FAULT;
         endcase
      end
   end

   // Strobes are gated by reset so nothing is requested while reset is held.
   always_comb begin
      bus.mem_read  = 1'b0;
      bus.mem_write = 1'b0;
      bus.iord      = 1'b0;
      bus.ir_write  = 1'b0;
      bus.pc_write  = 1'b0;
      bus.pc_sel    = 2'd0;
      bus.branch    = 1'b0;
      bus.reg_write = 1'b0;
      bus.wb_sel    = 2'd0;
      bus.alu_src   = 1'b0;
      bus.alu_op    = '0;
      bus.busy      = 1'b0;
      bus.fault     = 1'b0;
      if (!reset) begin
         case (state)
            S_FETCH: begin
               bus.mem_read = 1'b1;
               bus.ir_write = bus.mem_ready;
               bus.pc_write = bus.mem_ready;
            end
            S_DECODE: bus.busy = 1'b1;
            S_EXEC: begin
               bus.busy    = 1'b1;
               bus.alu_op  = dec_alu;
               bus.alu_src = dec_src;
               if (kind == K_BRANCH) begin
                  bus.branch = 1'b1;
                  bus.pc_sel = 2'd1;
               end else if (kind == K_JAL || kind == K_JALR) begin
                  bus.pc_write = 1'b1;
                  bus.pc_sel   = (kind == K_JAL) ? 2'd1 : 2'd2;
               end
            end
            S_MEM: begin
               bus.busy      = 1'b1;
               bus.iord      = 1'b1;
               bus.mem_read  = (kind == K_LOAD);
               bus.mem_write = (kind == K_STORE);
            end
            S_WB: begin
               bus.busy      = 1'b1;
               bus.reg_write = 1'b1;
               if (kind == K_LOAD)                         bus.wb_sel = 2'd1;
               else if (kind == K_JAL || kind == K_JALR)   bus.wb_sel = 2'd2;
            end
            default: begin
               bus.busy  = 1'b1;
               bus.fault = 1'b1;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Bench for multicycle_control_fsm: per-instruction expected cycle traces built from the
// instruction class and the chosen memory wait counts, compared every cycle.
module tb_multicycle_control_fsm;
   localparam int MAX_WAIT = 15;
   localparam int PF = 0, PD = 1, PE = 2, PM = 3, PW = 4, PX = 5;
   localparam int C_ALU = 0, C_LD = 1, C_ST = 2, C_BR = 3, C_JAL = 4, C_JALR = 5, C_BAD = 6;

   typedef struct {
      int ph;
      bit rdy;
   } step_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   nvec = 0;
   int   nerr = 0;
   int   rtab [8] = '{0, 4, 7, 9, 6, 5, 3, 2};
   logic [6:0] optab [10] = '{7'h33, 7'h13, 7'h37, 7'h17, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h7F};

   always #5 clk = ~clk;

   multicycle_control_if #(.ALUOP_W(4)) bus ();

   multicycle_control_fsm #(.ALUOP_W(4), .WAIT_W(4), .MAX_WAIT(MAX_WAIT)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   logic [31:0] obs;
   assign obs = {14'd0, bus.mem_read, bus.mem_write, bus.iord, bus.ir_write, bus.pc_write,
                 bus.pc_sel, bus.branch, bus.reg_write, bus.wb_sel, bus.alu_src, bus.alu_op,
                 bus.busy, bus.fault};

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nvec++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic void classify(input logic [31:0] ins, output int cls, output int alu,
                                    output bit src);
      logic [6:0] op = ins[6:0];
      logic [2:0] f3 = ins[14:12];
      logic [6:0] f7 = ins[31:25];
      bit ok = 1'b1;
      cls = C_BAD;
      alu = 0;
      src = 1'b1;
      case (op)
         7'h33: begin
            cls = C_ALU; src = 1'b0; alu = rtab[f3];
            ok  = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
            if (f7 == 7'h20) alu = (f3 == 3'd0) ? 1 : 8;
         end
         7'h13: begin
            cls = C_ALU; alu = rtab[f3];
            if (f3 == 3'd1) ok = (f7 == 7'h00);
            if (f3 == 3'd5) begin
               ok = (f7 == 7'h00) || (f7 == 7'h20);
               if (f7 == 7'h20) alu = 8;
            end
         end
         7'h37: begin cls = C_ALU; alu = 10; end
         7'h17: cls = C_ALU;
         7'h03: begin cls = C_LD; ok = (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}); end
         7'h23: begin cls = C_ST; ok = (f3 <= 3'd2); end
         7'h63: begin
            cls = C_BR; src = 1'b0;
            ok  = !(f3 == 3'd2 || f3 == 3'd3);
            alu = (f3 < 3'd2) ? 1 : ((f3 < 3'd6) ? 7 : 9);
         end
         7'h6F: cls = C_JAL;
         7'h67: begin cls = C_JALR; ok = (f3 == 3'd0); end
         default: ok = 1'b0;
      endcase
      if (!ok) cls = C_BAD;
   endfunction

   function automatic logic [31:0] expv(int ph, bit rdy, int cls, int alu, bit src);
      logic mr = 0, mw = 0, io = 0, irw = 0, pcw = 0, br = 0, rw = 0, as = 0, bz = 0, ft = 0;
      logic [1:0] ps = 0, wb = 0;
      logic [3:0] ao = 0;
      case (ph)
         PF: begin mr = 1; irw = rdy; pcw = rdy; end
         PD: bz = 1;
         PE: begin
            bz = 1; ao = 4'(alu); as = src;
            if (cls == C_BR)   begin br = 1; ps = 2'd1; end
            if (cls == C_JAL)  begin pcw = 1; ps = 2'd1; end
            if (cls == C_JALR) begin pcw = 1; ps = 2'd2; end
         end
         PM: begin bz = 1; io = 1; mr = (cls == C_LD); mw = (cls == C_ST); end
         PW: begin
            bz = 1; rw = 1;
            wb = (cls == C_LD) ? 2'd1 : ((cls == C_JAL || cls == C_JALR) ? 2'd2 : 2'd0);
         end
         PX: begin bz = 1; ft = 1; end
         default: ;
      endcase
      return {14'd0, mr, mw, io, irw, pcw, ps, br, rw, wb, as, ao, bz, ft};
   endfunction

   // Reset is held across the next rising edge and released by the next instruction's first step.
   task automatic hold_reset(input string name);
      reset = 1'b1;
      bus.mem_ready = 1'($urandom);
      #1 chk({name, "_rst"}, obs, 32'd0);
   endtask

   task automatic run_instr(input logic [31:0] ins, input int fw, input int mw,
                            input int rst_at, input string name);
      step_t q[$];
      int cls, alu, n;
      bit src;
      classify(ins, cls, alu, src);
      n = (fw > MAX_WAIT) ? MAX_WAIT + 1 : fw;
      for (int i = 0; i < n; i++) q.push_back('{PF, 1'b0});
      if (fw > MAX_WAIT) q.push_back('{PX, 1'b0});
      else begin
         q.push_back('{PF, 1'b1});
         q.push_back('{PD, 1'b0});
         if (cls == C_BAD) begin
`ifdef ILLEGAL_TRAP_EN
            q.push_back('{PX, 1'b0});
`endif
         end else begin
            q.push_back('{PE, 1'b0});
            if (cls == C_LD || cls == C_ST) begin
               n = (mw > MAX_WAIT) ? MAX_WAIT + 1 : mw;
               for (int i = 0; i < n; i++) q.push_back('{PM, 1'b0});
               if (mw > MAX_WAIT) q.push_back('{PX, 1'b0});
               else q.push_back('{PM, 1'b1});
            end
            if (q[$].ph != PX && cls != C_ST && cls != C_BR) q.push_back('{PW, 1'b0});
         end
      end
      for (int k = 0; k < q.size(); k++) begin
         @(negedge clk);
         bus.instr = ins;
         reset = 1'b0;
         if (k == rst_at) begin
            hold_reset(name);
            return;
         end
         bus.mem_ready = q[k].rdy;
         #1 chk($sformatf("%s#%0d", name, k), obs, expv(q[k].ph, q[k].rdy, cls, alu, src));
      end
      if (q[$].ph == PX) begin
         @(negedge clk);
         bus.mem_ready = 1'b1;
         #1 chk({name, "_sticky"}, obs, expv(PX, 1'b1, cls, alu, src));
         @(negedge clk);
         hold_reset(name);
      end
   endtask

   function automatic int pick_wait();
      int r = $urandom_range(0, 39);
      if (r < 24) return 0;
      if (r < 37) return $urandom_range(1, 4);
      if (r < 39) return MAX_WAIT;
      return MAX_WAIT + 1;
   endfunction

   initial begin
      logic [31:0] ins;
      bus.instr = 32'd0;
      bus.mem_ready = 1'b0;
      @(negedge clk);
      #1 chk("reset_state", obs, 32'd0);

      run_instr(32'h002081B3, 0, 0, -1, "add");
      run_instr(32'h0000A183, 0, 3, -1, "lw_wait");
      run_instr(32'h0020A023, 0, 0, -1, "sw");
      run_instr(32'h00208063, 0, 0, -1, "beq");
      run_instr(32'h008000EF, 0, 0, -1, "jal");
      run_instr(32'h000080E7, 0, 0, -1, "jalr");
      run_instr(32'h123450B7, 0, 0, -1, "lui");
      run_instr(32'h4020D1B3, 1, 0, -1, "sra");
      run_instr(32'h00000013, MAX_WAIT + 1, 0, -1, "fetch_to");
      run_instr(32'h002081B3, MAX_WAIT, 0, -1, "fetch_edge");
      run_instr(32'h0000A183, 0, MAX_WAIT, -1, "mem_edge");
      run_instr(32'h0020A023, 0, MAX_WAIT + 1, -1, "mem_to");
      run_instr(32'h0000007F, 0, 0, -1, "ill_7f");
      run_instr(32'h0020A023, 0, 5, 4, "sw_rst");
      run_instr(32'h002081B3, 0, 0, -1, "after_rst");

      for (int t = 0; t < 400; t++) begin
         ins = $urandom;
         ins[6:0] = optab[$urandom_range(0, 9)];
         if ($urandom_range(0, 3) != 0) ins[31:25] = ($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00;
         run_instr(ins, pick_wait(), pick_wait(), -1, $sformatf("rnd%0d_%h", t, ins));
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
